// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: walks each instruction through fetch/decode/execute/memory/
// writeback and drives the datapath controls, with memory-ready timeout and a retire counter.
module mc_control_fsm #(
    parameter int unsigned OP_W        = 6,
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OP_W-1:0]     instr_op_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                branch_ne_o,
    output logic [1:0]          pc_src_o,
    output logic                ir_write_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                mem_to_reg_o,
    output logic                reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                illegal_o,
    output logic                err_o,
    output logic [3:0]          state_o,
    output logic [CNT_W-1:0]    instr_cnt_o
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StExecI   = 4'd10,
        StError   = 4'd15
    } state_e;

    localparam logic [OP_W-1:0] OpRType = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OpAddi  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OpSlti  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OpLw    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OpSw    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OpBeq   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OpBne   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OpJ     = OP_W'(6'b000010);

    // Wide enough to hold MEM_TIMEOUT plus headroom; the counter saturates.
    localparam int unsigned      WaitW     = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT);

    state_e           stateQ, stateD;
    logic [WaitW-1:0] waitQ, waitD, waitInc;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             waiting, timeout, retire;
    logic [2:0]       aluOp;

    always_comb begin
        waitInc = (waitQ == {WaitW{1'b1}}) ? waitQ : waitQ + 1'b1;
        waiting = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);
        // Ready in the limit cycle wins, so the timeout needs ready still low.
        timeout = (MEM_TIMEOUT != 0) && !mem_ready_i && (waitInc >= WaitLimit);
        waitD   = (waiting && !mem_ready_i) ? waitInc : '0;
    end

    always_comb begin
        stateD          = stateQ;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        pc_src_o        = 2'b00;
        ir_write_o      = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        aluOp           = 3'b000;
        illegal_o       = 1'b0;
        err_o           = 1'b0;

        unique case (stateQ)
            StFetch: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) stateD = StDecode;
                else if (timeout) stateD = StError;
            end
            StDecode: begin
                alu_src_b_o = 2'b11;
                case (instr_op_i)
                    OpRType:       stateD = StExecR;
                    OpAddi, OpSlti: stateD = StExecI;
                    OpLw, OpSw:    stateD = StMemAddr;
                    OpBeq, OpBne:  stateD = StBranch;
                    OpJ:           stateD = StJump;
                    default: begin
                        illegal_o = 1'b1;
                        stateD    = StFetch;
                    end
                endcase
            end
            StExecR: begin
                alu_src_a_o = 1'b1;
                aluOp       = 3'b010;
                stateD      = StAluWb;
            end
            StExecI: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                aluOp       = (instr_op_i == OpSlti) ? 3'b100 : 3'b000;
                stateD      = StAluWb;
            end
            StAluWb: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (instr_op_i == OpRType);
                stateD      = StFetch;
            end
            StMemAddr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                stateD      = (instr_op_i == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
                if (mem_ready_i) stateD = StMemWb;
                else if (timeout) stateD = StError;
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                stateD       = StFetch;
            end
            StMemWr: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
                if (mem_ready_i) stateD = StFetch;
                else if (timeout) stateD = StError;
            end
            StBranch: begin
                alu_src_a_o     = 1'b1;
                aluOp           = 3'b001;
                pc_write_cond_o = 1'b1;
                branch_ne_o     = (instr_op_i == OpBne);
                pc_src_o        = 2'b01;
                stateD          = StFetch;
            end
            StJump: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
                stateD     = StFetch;
            end
            StError: err_o = 1'b1;
            default: stateD = StFetch;
        endcase

        alu_op_o    = ALU_OP_W'(aluOp);
        state_o     = stateQ;
        instr_cnt_o = cntQ;

        // Outputs read as zero for the whole reset cycle, whatever state is held.
        if (rst_i) begin
            pc_write_o      = 1'b0;
            pc_write_cond_o = 1'b0;
            branch_ne_o     = 1'b0;
            pc_src_o        = 2'b00;
            ir_write_o      = 1'b0;
            iord_o          = 1'b0;
            mem_read_o      = 1'b0;
            mem_write_o     = 1'b0;
            mem_to_reg_o    = 1'b0;
            reg_dst_o       = 1'b0;
            reg_write_o     = 1'b0;
            alu_src_a_o     = 1'b0;
            alu_src_b_o     = 2'b00;
            alu_op_o        = '0;
            illegal_o       = 1'b0;
            err_o           = 1'b0;
            state_o         = 4'd0;
            instr_cnt_o     = '0;
        end
    end

    always_comb begin
        retire = (stateD == StFetch) &&
                 (stateQ inside {StAluWb, StMemWb, StMemWr, StBranch, StJump});
        cntD   = retire ? cntQ + 1'b1 : cntQ;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ <= StFetch;
            waitQ  <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            waitQ  <= waitD;
            cntQ   <= cntD;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each cycle pushes the expected state, control vector and
// retire count; a negedge monitor pops and compares them against the DUT.
module tb_mc_control_fsm;

    localparam int unsigned AluW = 4;

    // Control vector layout, MSB first:
    // pcw, pcwc, bne, pc_src[1:0], irw, iord, mrd, mwr, m2r, rdst, rw, srca, srcb[1:0],
    // alu_op[3:0], illegal, err
    localparam logic [20:0] PcW     = 21'd1 << 20;
    localparam logic [20:0] PcWc    = 21'd1 << 19;
    localparam logic [20:0] Bne     = 21'd1 << 18;
    localparam logic [20:0] PcSrc10 = 21'd1 << 17;
    localparam logic [20:0] PcSrc01 = 21'd1 << 16;
    localparam logic [20:0] IrW     = 21'd1 << 15;
    localparam logic [20:0] IorD    = 21'd1 << 14;
    localparam logic [20:0] MRd     = 21'd1 << 13;
    localparam logic [20:0] MWr     = 21'd1 << 12;
    localparam logic [20:0] M2R     = 21'd1 << 11;
    localparam logic [20:0] RDst    = 21'd1 << 10;
    localparam logic [20:0] RW      = 21'd1 << 9;
    localparam logic [20:0] SrcA    = 21'd1 << 8;
    localparam logic [20:0] SrcB10  = 21'd2 << 6;
    localparam logic [20:0] SrcB01  = 21'd1 << 6;
    localparam logic [20:0] SrcB11  = 21'd3 << 6;
    localparam logic [20:0] AluSlt  = 21'd4 << 2;
    localparam logic [20:0] AluR    = 21'd2 << 2;
    localparam logic [20:0] AluSub  = 21'd1 << 2;
    localparam logic [20:0] Ill     = 21'd1 << 1;
    localparam logic [20:0] Err     = 21'd1;

    localparam logic [20:0] CZero   = 21'd0;
    localparam logic [20:0] CFetchR = PcW | IrW | MRd | SrcB01;
    localparam logic [20:0] CFetchW = MRd | SrcB01;
    localparam logic [20:0] CDecode = SrcB11;
    localparam logic [20:0] CDecIll = SrcB11 | Ill;
    localparam logic [20:0] CExecR  = SrcA | AluR;
    localparam logic [20:0] CAddi   = SrcA | SrcB10;
    localparam logic [20:0] CSlti   = SrcA | SrcB10 | AluSlt;
    localparam logic [20:0] CAluWbR = RW | RDst;
    localparam logic [20:0] CAluWbI = RW;
    localparam logic [20:0] CMemAdr = SrcA | SrcB10;
    localparam logic [20:0] CMemRd  = IorD | MRd;
    localparam logic [20:0] CMemWb  = RW | M2R;
    localparam logic [20:0] CMemWr  = IorD | MWr;
    localparam logic [20:0] CBeq    = SrcA | AluSub | PcWc | PcSrc01;
    localparam logic [20:0] CBne    = CBeq | Bne;
    localparam logic [20:0] CJump   = PcW | PcSrc10;
    localparam logic [20:0] CError  = Err;

    typedef struct packed {
        logic [3:0]  st;
        logic [20:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [5:0]      instrOp;
    logic            memReady;
    logic            pcWrite, pcWriteCond, branchNe, irWrite, iord, memRead, memWrite;
    logic            memToReg, regDst, regWrite, aluSrcA, illegal, err;
    logic [1:0]      pcSrc, aluSrcB;
    logic [AluW-1:0] aluOp;
    logic [3:0]      state;
    logic [31:0]     instrCnt;
    logic [20:0]     obsCtl;

    exp_t        sbQ[$];
    exp_t        cur;
    int unsigned expCnt;
    int          nChecks;
    int          nErrors;
    int          cycIdx;

    mc_control_fsm #(
        .OP_W        (6),
        .ALU_OP_W    (AluW),
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_op_i      (instrOp),
        .mem_ready_i     (memReady),
        .pc_write_o      (pcWrite),
        .pc_write_cond_o (pcWriteCond),
        .branch_ne_o     (branchNe),
        .pc_src_o        (pcSrc),
        .ir_write_o      (irWrite),
        .iord_o          (iord),
        .mem_read_o      (memRead),
        .mem_write_o     (memWrite),
        .mem_to_reg_o    (memToReg),
        .reg_dst_o       (regDst),
        .reg_write_o     (regWrite),
        .alu_src_a_o     (aluSrcA),
        .alu_src_b_o     (aluSrcB),
        .alu_op_o        (aluOp),
        .illegal_o       (illegal),
        .err_o           (err),
        .state_o         (state),
        .instr_cnt_o     (instrCnt)
    );

    assign obsCtl = {pcWrite, pcWriteCond, branchNe, pcSrc, irWrite, iord, memRead, memWrite,
                     memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, illegal, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus just after the rising edge and queue what the DUT must show.
    task automatic step(input logic [5:0] op, input logic rdy, input logic rstV,
                        input logic [3:0] st, input logic [20:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        instrOp  = op;
        memReady = rdy;
        rst      = rstV;
        e.st     = st;
        e.ctl    = ctl;
        e.cnt    = expCnt;
        sbQ.push_back(e);
    endtask

    task automatic test_reset();
        expCnt = 0;
        step(6'h3f, 1'b1, 1'b1, 4'd0, CZero);
        step(6'h3f, 1'b1, 1'b1, 4'd0, CZero);
    endtask

    task automatic test_rtype();
        step(6'h00, 1'b1, 1'b0, 4'd0, CFetchR);
        #1;
        nChecks++;
        if (instrCnt !== 32'd0) begin
            nErrors++;
            $display("FAIL rtype_cnt_start: got %0d want 0", instrCnt);
        end
        step(6'h00, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h00, 1'b1, 1'b0, 4'd6, CExecR);
        step(6'h00, 1'b1, 1'b0, 4'd7, CAluWbR);
        expCnt++;
    endtask

    task automatic test_lw();
        step(6'h23, 1'b1, 1'b0, 4'd0, CFetchR);
        #1;
        nChecks++;
        if (instrCnt !== 32'd1) begin
            nErrors++;
            $display("FAIL lw_cnt_start: got %0d want 1", instrCnt);
        end
        step(6'h23, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h23, 1'b1, 1'b0, 4'd2, CMemAdr);
        step(6'h23, 1'b0, 1'b0, 4'd3, CMemRd);
        step(6'h23, 1'b0, 1'b0, 4'd3, CMemRd);
        step(6'h23, 1'b1, 1'b0, 4'd3, CMemRd);
        step(6'h23, 1'b1, 1'b0, 4'd4, CMemWb);
        expCnt++;
    endtask

    task automatic test_branch();
        step(6'h04, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h04, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h04, 1'b1, 1'b0, 4'd8, CBeq);
        expCnt++;
        step(6'h05, 1'b1, 1'b0, 4'd0, CFetchR);
        #1;
        nChecks++;
        if (instrCnt !== 32'd3) begin
            nErrors++;
            $display("FAIL branch_cnt_mid: got %0d want 3", instrCnt);
        end
        step(6'h05, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h05, 1'b1, 1'b0, 4'd8, CBne);
        #1;
        nChecks++;
        if (branchNe !== 1'b1) begin
            nErrors++;
            $display("FAIL bne_flag: got %b want 1", branchNe);
        end
        expCnt++;
    endtask

    task automatic test_itype_jump();
        step(6'h08, 1'b0, 1'b0, 4'd0, CFetchW);
        step(6'h08, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h08, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h08, 1'b1, 1'b0, 4'd10, CAddi);
        step(6'h08, 1'b1, 1'b0, 4'd7, CAluWbI);
        expCnt++;
        step(6'h0a, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h0a, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h0a, 1'b1, 1'b0, 4'd10, CSlti);
        step(6'h0a, 1'b1, 1'b0, 4'd7, CAluWbI);
        expCnt++;
        step(6'h02, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h02, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h02, 1'b1, 1'b0, 4'd9, CJump);
        expCnt++;
    endtask

    task automatic test_illegal();
        step(6'h3f, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h3f, 1'b1, 1'b0, 4'd1, CDecIll);
        #1;
        nChecks++;
        if (illegal !== 1'b1) begin
            nErrors++;
            $display("FAIL illegal_pulse: got %b want 1", illegal);
        end
        step(6'h11, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h11, 1'b1, 1'b0, 4'd1, CDecIll);
    endtask

    task automatic test_sw_ready_at_limit();
        step(6'h2b, 1'b1, 1'b0, 4'd0, CFetchR);
        #1;
        nChecks++;
        if (instrCnt !== 32'd7) begin
            nErrors++;
            $display("FAIL illegal_not_counted: got %0d want 7", instrCnt);
        end
        step(6'h2b, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h2b, 1'b1, 1'b0, 4'd2, CMemAdr);
        for (int i = 0; i < 3; i++) step(6'h2b, 1'b0, 1'b0, 4'd5, CMemWr);
        step(6'h2b, 1'b1, 1'b0, 4'd5, CMemWr);
        expCnt++;
    endtask

    task automatic test_timeout();
        step(6'h2b, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h2b, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h2b, 1'b0, 1'b0, 4'd2, CMemAdr);
        for (int i = 0; i < 4; i++) step(6'h2b, 1'b0, 1'b0, 4'd5, CMemWr);
        for (int i = 0; i < 3; i++) step(6'h2b, 1'b1, 1'b0, 4'd15, CError);
        #1;
        nChecks++;
        if (err !== 1'b1 || state !== 4'd15) begin
            nErrors++;
            $display("FAIL err_sticky: got err=%b state=%0d want err=1 state=15", err, state);
        end
    endtask

    task automatic test_reset_mid();
        expCnt = 0;
        step(6'h23, 1'b1, 1'b1, 4'd0, CZero);
        #1;
        nChecks++;
        if (err !== 1'b0) begin
            nErrors++;
            $display("FAIL err_cleared: got %b want 0", err);
        end
        step(6'h23, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h23, 1'b1, 1'b0, 4'd1, CDecode);
        step(6'h23, 1'b1, 1'b0, 4'd2, CMemAdr);
        step(6'h23, 1'b0, 1'b0, 4'd3, CMemRd);
        step(6'h23, 1'b1, 1'b1, 4'd0, CZero);
        step(6'h23, 1'b1, 1'b0, 4'd0, CFetchR);
        step(6'h23, 1'b1, 1'b0, 4'd1, CDecode);
    endtask

    initial begin
        rst      = 1'b1;
        instrOp  = 6'h00;
        memReady = 1'b0;
        nChecks  = 0;
        nErrors  = 0;
        cycIdx   = 0;
        expCnt   = 0;

        fork
            forever begin
                @(negedge clk);
                if (sbQ.size() > 0) begin
                    cur = sbQ.pop_front();
                    nChecks++;
                    if (state !== cur.st) begin
                        nErrors++;
                        $display("FAIL state cyc%0d: got %0d want %0d", cycIdx, state, cur.st);
                    end
                    nChecks++;
                    if (obsCtl !== cur.ctl) begin
                        nErrors++;
                        $display("FAIL ctl cyc%0d: got %h want %h", cycIdx, obsCtl, cur.ctl);
                    end
                    nChecks++;
                    if (instrCnt !== cur.cnt) begin
                        nErrors++;
                        $display("FAIL cnt cyc%0d: got %0d want %0d", cycIdx, instrCnt, cur.cnt);
                    end
                    cycIdx++;
                end
            end
        join_none

        test_reset();
        test_rtype();
        test_lw();
        test_branch();
        test_itype_jump();
        test_illegal();
        test_sw_ready_at_limit();
        test_timeout();
        test_reset_mid();

        @(negedge clk);
        #1;
        nChecks++;
        if (sbQ.size() != 0) begin
            nErrors++;
            $display("FAIL sb_drain: got %0d pending want 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control unit; successor to the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux/strobe controls per state.
- Adds a memory ready handshake with timeout, illegal-opcode trapping, bne and j support, and a retired-instruction counter.
- Sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
OP_W, 6, opcode width.
ALU_OP_W, 3, ALU op width (>=3); bits above [2:0] are always driven 0.
MEM_TIMEOUT, 16, max cycles to wait for mem_ready_i; 0 disables the timeout.
CNT_W, 32, retired-instruction counter width.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous, active-high reset.
instr_op_i  in  OP_W  opcode from IR; stable from DECODE until the next FETCH.
mem_ready_i  in  1  memory completes the current read/write this cycle.
pc_write_o  out  1  unconditional PC load.
pc_write_cond_o  out  1  PC load if branch condition holds.
branch_ne_o  out  1  1 = condition is !zero (bne), 0 = zero (beq).
pc_src_o  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
ir_write_o  out  1  IR load.
iord_o  out  1  memory address: 0 = PC, 1 = ALUOut.
mem_read_o  out  1  memory read request.
mem_write_o  out  1  memory write request.
mem_to_reg_o  out  1  writeback source: 1 = MDR.
reg_dst_o  out  1  1 = rd, 0 = rt.
reg_write_o  out  1  register file write.
alu_src_a_o  out  1  0 = PC, 1 = rs.
alu_src_b_o  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
alu_op_o  out  ALU_OP_W  000 add, 001 sub, 010 R-type funct, 100 slt.
illegal_o  out  1  one-cycle pulse on an unsupported opcode.
err_o  out  1  sticky memory-timeout error.
state_o  out  4  current state encoding.
instr_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- While rst_i=1:
  - All outputs 0.
  - State <= FETCH; err_o, wait counter and instr_cnt_o <= 0.
  - Reset overrides any state, including mid-wait.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, ALU_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, ERROR=15.
- Outputs are Moore from state except where marked (ready). Every strobe not listed for a state is 0. No x values are ever driven.
- FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=add, pc_src=00.
  - ir_write=pc_write=mem_ready_i (ready).
  - Stay until ready, then go to DECODE.
- DECODE: src_a=0, src_b=11, alu_op=add (branch target precompute). Next state by opcode:
  - 000000 -> EXEC_R
  - 001000 (addi) -> EXEC_I
  - 001010 (slti) -> EXEC_I
  - 100011 (lw) -> MEM_ADDR
  - 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - Any other opcode: illegal_o=1 this cycle, go to FETCH, not counted.
- EXEC_R: src_a=1, src_b=00, alu_op=010; go to ALU_WB.
- EXEC_I: src_a=1, src_b=10, alu_op = 100 if slti else 000; go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=(opcode==000000); go to FETCH.
- MEM_ADDR: src_a=1, src_b=10, alu_op=add; go to MEM_RD if lw, else MEM_WR.
- MEM_RD: iord=1, mem_read=1; wait for ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; go to FETCH.
- MEM_WR: iord=1, mem_write=1; wait for ready, then go to FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=sub, pc_write_cond=1, branch_ne=(opcode==000101), pc_src=01; go to FETCH.
- JUMP: pc_write=1, pc_src=10; go to FETCH.
- Latency with ready held high:
  - R/addi/slti/sw: 4 cycles.
  - lw: 5 cycles.
  - beq/bne/j: 3 cycles.
  - Each ready-low cycle in FETCH/MEM_RD/MEM_WR adds 1 cycle.
- Wait counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR.
  - Increments each cycle in those states with mem_ready_i=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with ready still 0, go to ERROR next cycle.
  - Ready in the same cycle the limit is reached wins; no error.
- ERROR: all strobes 0, err_o=1; stay until rst_i.
- instr_cnt_o increments by 1 on each transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP. Wraps modulo 2^CNT_W.

Test Plan:
- Reset, then opcode 000000, ready=1 -> states 0,1,6,7; reg_write=1 and reg_dst=1 in cycle 4; instr_cnt_o=1.
- lw (100011), ready low 2 cycles in MEM_RD -> 7 cycles total; MEM_WB has reg_write=1, mem_to_reg=1, reg_dst=0.
- beq then bne -> 3 cycles each; pc_write_cond=1 in BRANCH; branch_ne=0 then 1; pc_src=01; instr_cnt_o=2.
- Opcode 111111 -> illegal_o pulses 1 cycle in DECODE; returns to FETCH; instr_cnt_o unchanged.
- MEM_TIMEOUT=4, sw with ready held 0 -> ERROR (state_o=15) after 4 wait cycles; err_o stays 1 until rst_i; ready on the 4th cycle instead -> no error.
- rst_i asserted in MEM_RD -> next cycle state_o=0, all outputs 0, instr_cnt_o=0, err_o=0.
